writeback_unit: RTL

//  Sole driver of the register file write port (rd_addr/rd_data) and owner of the

---
 rtl/writeback_unit_pkg.sv | 23 ++
 rtl/writeback_unit_reg_scoreboard.sv | 67 ++++++
 rtl/writeback_unit.sv | 121 ++++++++++++
 3 files changed

// File: rtl/writeback_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit_pkg
//  Brief    : Shared types and constants for the register write-back path.
//  Revision : 1.0 - initial release
// ============================================================================
package writeback_unit_pkg;

    localparam int NUM_REGS = 32;

    typedef logic [31:0] u32_t;
    typedef logic [4:0]  regaddr_t;

    // One write request: destination register and the value to write.
    typedef struct packed {
        regaddr_t addr;
        u32_t     data;
    } wb_req_t;

    localparam regaddr_t C_REG_ZERO = 5'd0;

endpackage : writeback_unit_pkg
`default_nettype wire

// File: rtl/writeback_unit_reg_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : reg_scoreboard
//  Brief    : Busy vector for registers with long ops in flight, hazard lookup
//             on three addresses, and a registered count of busy registers.
//  Revision : 1.0 - initial release
// ============================================================================
module reg_scoreboard #(
    parameter int NUM_REGS = writeback_unit_pkg::NUM_REGS
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [4:0]          set_addr,
    input  logic                clr_en,
    input  logic [4:0]          clr_addr,
    input  logic                chk_en,
    input  logic [4:0]          chk_ra,
    input  logic [4:0]          chk_rb,
    input  logic [4:0]          chk_rd,
    output logic                hazard,
    output logic [NUM_REGS-1:0] busy,
    output logic [5:0]          pend_cnt
);
    import writeback_unit_pkg::*;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_nxt;
    logic [5:0]          r_pend_cnt;
    logic [5:0]          w_pend_nxt;

    // Set is applied after clear so a fresh issue keeps ownership of the register.
    always_comb begin
        w_busy_nxt = r_busy;
        if (clr_en) begin
            w_busy_nxt[clr_addr] = 1'b0;
        end
        if (set_en) begin
            w_busy_nxt[set_addr] = 1'b1;
        end
        w_busy_nxt[C_REG_ZERO] = 1'b0;
    end

    always_comb begin
        w_pend_nxt = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            w_pend_nxt = w_pend_nxt + {5'd0, w_busy_nxt[i]};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy     <= '0;
            r_pend_cnt <= '0;
        end else begin
            r_busy     <= w_busy_nxt;
            r_pend_cnt <= w_pend_nxt;
        end
    end

    // Uses the registered vector, so a register clearing this cycle still hazards.
    assign hazard   = chk_en & (r_busy[chk_ra] | r_busy[chk_rb] | r_busy[chk_rd]);
    assign busy     = r_busy;
    assign pend_cnt = r_pend_cnt;

endmodule : reg_scoreboard
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
//  Module   : writeback_unit
//  Brief    : Arbitrates ALU and long-latency results into one registered
//             register-file write stage, forwards it, and stalls on hazards.
//  Revision : 1.0 - initial release
// ============================================================================
module writeback_unit #(
    parameter int NUM_REGS = writeback_unit_pkg::NUM_REGS,
    parameter bit FWD_EN   = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        alu_valid,
    input  logic [4:0]  alu_addr,
    input  logic [31:0] alu_data,
    input  logic        lng_valid,
    output logic        lng_ready,
    input  logic [4:0]  lng_addr,
    input  logic [31:0] lng_data,
    input  logic        iss_valid,
    input  logic        iss_long,
    input  logic [4:0]  iss_rd,
    input  logic [4:0]  iss_ra,
    input  logic [4:0]  iss_rb,
    output logic        iss_stall,
    input  logic [31:0] rf_ra_data,
    input  logic [31:0] rf_rb_data,
    output logic [31:0] ra_fwd_data,
    output logic [31:0] rb_fwd_data,
    output logic [4:0]  rd_addr,
    output logic [31:0] rd_data,
    output logic [5:0]  pend_cnt
);
    import writeback_unit_pkg::*;

    wb_req_t             w_alu_req;
    wb_req_t             w_lng_req;
    wb_req_t             w_win;
    wb_req_t             r_stage;
    logic                w_lng_fire;
    logic                w_set_en;
    logic                w_hazard;
    logic [NUM_REGS-1:0] w_busy;

    assign w_alu_req  = {alu_addr, alu_data};
    assign w_lng_req  = {lng_addr, lng_data};

    // ALU results have no back-pressure, so the long stream yields to them.
    assign lng_ready  = rst_n & ~alu_valid;
    assign w_lng_fire = lng_valid & lng_ready;

    always_comb begin
        w_win = '0;
        if (alu_valid) begin
            w_win = w_alu_req;
        end else if (w_lng_fire) begin
            w_win = w_lng_req;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stage <= '0;
        end else begin
            r_stage <= w_win;
        end
    end

    assign rd_addr = r_stage.addr;
    assign rd_data = r_stage.data;

    assign w_set_en  = iss_valid & iss_long & ~w_hazard & (iss_rd != C_REG_ZERO);
    assign iss_stall = w_hazard;

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .set_en   (w_set_en),
        .set_addr (iss_rd),
        .clr_en   (w_lng_fire),
        .clr_addr (lng_addr),
        .chk_en   (iss_valid),
        .chk_ra   (iss_ra),
        .chk_rb   (iss_rb),
        .chk_rd   (iss_rd),
        .hazard   (w_hazard),
        .busy     (w_busy),
        .pend_cnt (pend_cnt)
    );

    // The register file reads combinationally, so the value being written this
    // cycle is not yet visible there and must be bypassed from the write stage.
    generate
        if (FWD_EN) begin : g_fwd
            assign ra_fwd_data = ((rd_addr != C_REG_ZERO) && (rd_addr == iss_ra)) ? rd_data : rf_ra_data;
            assign rb_fwd_data = ((rd_addr != C_REG_ZERO) && (rd_addr == iss_rb)) ? rd_data : rf_rb_data;
        end else begin : g_no_fwd
            assign ra_fwd_data = rf_ra_data;
            assign rb_fwd_data = rf_rb_data;
        end
    endgenerate

`ifndef SYNTHESIS
    a_lng_to_busy : assert property (@(posedge clk) disable iff (!rst_n)
        (w_lng_fire && (lng_addr != C_REG_ZERO)) |-> w_busy[lng_addr])
        else $error("long result written to a register with no op in flight");

    a_lng_hold : assert property (@(posedge clk) disable iff (!rst_n)
        (lng_valid && !lng_ready) |=> (lng_valid && $stable(lng_addr) && $stable(lng_data)))
        else $error("long result withdrawn or changed while not accepted");

    a_alu_to_free : assert property (@(posedge clk) disable iff (!rst_n)
        (alu_valid && (alu_addr != C_REG_ZERO)) |-> !w_busy[alu_addr])
        else $error("ALU result targets a register with a long op in flight");
`endif

endmodule : writeback_unit
`default_nettype wire
